audio_mixer_i2s: RTL
====================

# audio_mixer_i2s

Final audio output stage: sums the 16-bit signed outputs of all playback channels into one left and one right sample, applies master gain with saturation, and transmits the result as a standard I2S stream. It generates the bit clock and the LR clock; the LR clock is also fed back to every channel so the channels advance position once per frame. It sits directly downstream of the channel array and drives the DAC pins.

## Interface
- NUM_CHANNELS, 8: number of channel inputs, ≥1
- CLK_DIV, 4: clk cycles per bclk half-period, ≥2
- SETTLE_CYCLES, 2: clk cycles waited after lrclk rise before sampling channels
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- i_channelSamples  in  16*NUM_CHANNELS  signed channel outputs; channel i at [16*i+15:16*i]
- i_channelIsLeft  in  NUM_CHANNELS  1 routes channel i to left mix, 0 to right
- i_masterVolume  in  8  unsigned gain, 128 = unity
- o_bclk  out  1  I2S bit clock
- o_lrclk  out  1  I2S word select, 0 = left slot; also drives channel lrclk
- o_sdata  out  1  I2S serial data
- o_mixStrobe  out  1  one-clk pulse when a new mixed pair is latched
- o_clipped  out  1  one-clk pulse, coincident with o_mixStrobe, if either side saturated

## Operation
- Divider counter 0..CLK_DIV-1; o_bclk toggles on wrap. Slot counter 0..31 advances on each bclk falling edge.
- At the falling edge starting slot n: o_lrclk = (n ≥ 16); o_sdata = frame word bit for slot n−1 (32-bit word = {left, right}, MSB first); slot 0 carries the LSB of the previous frame's right sample (standard one-bclk I2S delay).
- Frame word loaded from pending registers at the start of slot 0.
- Mix FSM: IDLE → WAIT on detection of o_lrclk rising (slot 16) → ACCUM after SETTLE_CYCLES clk → SCALE after NUM_CHANNELS clk (one channel per cycle, index 0 first) → IDLE.
- ACCUM: sign-extend channel to 16+clog2(NUM_CHANNELS)+1 bits; add to left or right accumulator per i_channelIsLeft[i] (sampled at that cycle). Accumulators cleared on entering WAIT.
- SCALE: product = acc × {0, i_masterVolume}, arithmetic shift right 7 (floor), saturate to [−32768, 32767]; write pending left/right; pulse o_mixStrobe, o_clipped if any saturation.
- Required: SETTLE_CYCLES + NUM_CHANNELS + 2 < 16·2·CLK_DIV (mix completes before slot 0). Elaboration-time check.

## Timing
- Reset values: o_bclk 0, o_lrclk 0, o_sdata 0, o_mixStrobe 0, o_clipped 0; counters 0; accumulators, pending and frame word 0; FSM IDLE. First frame after reset transmits zeros.
- bclk period 2·CLK_DIV clk; frame 64·CLK_DIV clk.
- Latency: channel values sampled mid-frame k appear on o_sdata in frame k+1 (MSB of left at slot 1).
- All outputs registered.
- Reset asserted mid-frame or mid-ACCUM: immediate return to reset values; partial mix discarded.
- i_masterVolume sampled only in SCALE; changes elsewhere have no effect until next mix.

## Configuration
- AUDIO_MIXER_MASTER_VOLUME_EN defined: gain stage as above.
- Undefined: no multiplier; i_masterVolume ignored; SCALE saturates raw accumulator directly.

## Structure
- audio_pkg: mixer FSM state enum (IDLE, WAIT, ACCUM, SCALE), SAMPLE_WIDTH = 16, I2S_SLOTS = 32, saturation limits.
- Sub-module i2s_transmitter: divider, slot counter, bclk/lrclk/sdata generation, frame-word load; exports slot-16 pulse to mixer FSM.

## Test plan
- Reset release, all inputs 0, CLK_DIV=4 → bclk period 8 clk, lrclk period 256 clk, sdata constant 0, one o_mixStrobe per frame.
- Channel 0 = 0x1234 left, volume 128 → next frame left word 0x1234, right 0x0000; left MSB one bclk after lrclk fall.
- Channels 0..3 left = 16000 each, volume 128 → left 32767, o_clipped pulse; all −16000 → −32768, o_clipped.
- Channel 1 right = 1000, volume 64 → right 500; −1001 → −501 (floor), no clip.
- Reset pulse during ACCUM → outputs return to reset values immediately; first frame after release all zeros.
- Macro undefined, volume 0, channel 0 left = 300, channel 2 left = −100 → left 200.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output stage: mixer FSM states,
// sample/slot geometry and saturation limits.
package audio_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int I2S_SLOTS    = 32;
  localparam int SAT_MAX      = 32767;
  localparam int SAT_MIN      = -32768;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCUM,
    SCALE
  } mixState_t;

endpackage

// File: rtl/i2s_transmitter.sv
// I2S serialiser: bit-clock divider, 32-slot frame counter, word-select and
// serial data generation, frame-word load at slot 0, slot-16 pulse for the mixer.
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2*SAMPLE_WIDTH-1:0] pendingWord,
  output logic                      bclk,
  output logic                      lrclk,
  output logic                      sdata,
  output logic                      slot16Pulse
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int SLOT_W = $clog2(I2S_SLOTS);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(I2S_SLOTS / 2);

  logic [DIV_W-1:0]          divCnt;
  logic [SLOT_W-1:0]         slotCnt;
  logic [SLOT_W-1:0]         slotNext;
  logic [SLOT_W-1:0]         bitSel;
  logic [2*SAMPLE_WIDTH-1:0] frameWord;
  logic                      divWrap;
  logic                      bclkFall;

  assign divWrap  = (divCnt == DIV_LAST);
  assign bclkFall = divWrap & bclk;
  assign slotNext = slotCnt + 1'b1;
  // Slot n carries word bit 32-n (mod 32): slot 0 gets bit 0 of the outgoing word.
  assign bitSel   = ~slotNext + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt      <= '0;
      slotCnt     <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      slot16Pulse <= 1'b0;
      frameWord   <= '0;
    end else begin
      slot16Pulse <= 1'b0;
      divCnt      <= divWrap ? '0 : divCnt + 1'b1;
      if (divWrap) begin
        bclk <= ~bclk;
      end
      if (bclkFall) begin
        slotCnt     <= slotNext;
        lrclk       <= (slotNext >= SLOT_HALF);
        slot16Pulse <= (slotNext == SLOT_HALF);
        sdata       <= frameWord[bitSel];
        if (slotNext == '0) begin
          frameWord <= pendingWord;
        end
      end
    end
  end

endmodule

// File: rtl/audio_mixer_i2s.sv
// Final audio stage: mixes all channels into left/right, applies master gain with
// saturation and streams the pair over I2S. Gain stage enabled by AUDIO_MIXER_MASTER_VOLUME_EN.
module audio_mixer_i2s
  import audio_pkg::*;
#(
  parameter int NUM_CHANNELS  = 8,
  parameter int CLK_DIV       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [SAMPLE_WIDTH*NUM_CHANNELS-1:0] i_channelSamples,
  input  logic [NUM_CHANNELS-1:0]              i_channelIsLeft,
  input  logic [7:0]                           i_masterVolume,
  output logic                                 o_bclk,
  output logic                                 o_lrclk,
  output logic                                 o_sdata,
  output logic                                 o_mixStrobe,
  output logic                                 o_clipped
);

  localparam int ACC_W       = SAMPLE_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam int IDX_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  generate
    if (NUM_CHANNELS < 1 || CLK_DIV < 2 || SETTLE_CYCLES < 0) begin : gBadParams
      $error("audio_mixer_i2s: NUM_CHANNELS >= 1, CLK_DIV >= 2, SETTLE_CYCLES >= 0 required");
    end
    if (SETTLE_CYCLES + NUM_CHANNELS + 2 >= 16 * 2 * CLK_DIV) begin : gBadTiming
      $error("audio_mixer_i2s: mix cannot complete within half a frame");
    end
  endgenerate

  mixState_t                       state;
  mixState_t                       stateNext;
  logic [SET_W-1:0]                settleCnt;
  logic [IDX_W-1:0]                chIdx;
  logic signed [ACC_W-1:0]         accL;
  logic signed [ACC_W-1:0]         accR;
  logic signed [SAMPLE_WIDTH-1:0]  pendL;
  logic signed [SAMPLE_WIDTH-1:0]  pendR;
  logic signed [SAMPLE_WIDTH-1:0]  chanSample;
  logic signed [ACC_W-1:0]         chanExt;
  logic                            slot16Pulse;
  logic [SAMPLE_WIDTH:0]           satL;
  logic [SAMPLE_WIDTH:0]           satR;

`ifdef AUDIO_MIXER_MASTER_VOLUME_EN
  localparam int SCL_W = ACC_W + 9;
  logic signed [SCL_W-1:0] scaledL;
  logic signed [SCL_W-1:0] scaledR;
  logic signed [SCL_W-1:0] gainExt;

  // Volume is a plain unsigned gain; 128 maps to unity after the >>>7.
  assign gainExt = SCL_W'($signed({1'b0, i_masterVolume}));
  assign scaledL = (SCL_W'(accL) * gainExt) >>> 7;
  assign scaledR = (SCL_W'(accR) * gainExt) >>> 7;
`else
  localparam int SCL_W = ACC_W;
  logic signed [SCL_W-1:0] scaledL;
  logic signed [SCL_W-1:0] scaledR;
  logic                    unusedVolume;

  assign unusedVolume = ^i_masterVolume;
  assign scaledL      = accL;
  assign scaledR      = accR;
`endif

  // Returns {clip, sample}: clamps to the 16-bit signed range.
  function automatic logic [SAMPLE_WIDTH:0] saturate(input logic signed [SCL_W-1:0] v);
    if (v > SCL_W'(SAT_MAX)) begin
      return {1'b1, SAMPLE_WIDTH'(SAT_MAX)};
    end else if (v < SCL_W'(SAT_MIN)) begin
      return {1'b1, SAMPLE_WIDTH'(SAT_MIN)};
    end
    return {1'b0, v[SAMPLE_WIDTH-1:0]};
  endfunction

  assign satL       = saturate(scaledL);
  assign satR       = saturate(scaledR);
  assign chanSample = i_channelSamples[SAMPLE_WIDTH*chIdx +: SAMPLE_WIDTH];
  assign chanExt    = ACC_W'(chanSample);

  i2s_transmitter #(
    .CLK_DIV(CLK_DIV)
  ) uTx (
    .clk        (clk),
    .rst_n      (rst_n),
    .pendingWord({pendL, pendR}),
    .bclk       (o_bclk),
    .lrclk      (o_lrclk),
    .sdata      (o_sdata),
    .slot16Pulse(slot16Pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (slot16Pulse) begin
          stateNext = (SETTLE_CYCLES == 0) ? ACCUM : WAIT;
        end
      end
      WAIT: begin
        if (settleCnt == SET_W'(SETTLE_LAST)) begin
          stateNext = ACCUM;
        end
      end
      ACCUM: begin
        if (chIdx == IDX_W'(NUM_CHANNELS - 1)) begin
          stateNext = SCALE;
        end
      end
      SCALE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Mix datapath: clear on leaving IDLE, one channel per ACCUM cycle, publish in SCALE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settleCnt   <= '0;
      chIdx       <= '0;
      accL        <= '0;
      accR        <= '0;
      pendL       <= '0;
      pendR       <= '0;
      o_mixStrobe <= 1'b0;
      o_clipped   <= 1'b0;
    end else begin
      o_mixStrobe <= 1'b0;
      o_clipped   <= 1'b0;
      case (state)
        IDLE: begin
          if (slot16Pulse) begin
            settleCnt <= '0;
            chIdx     <= '0;
            accL      <= '0;
            accR      <= '0;
          end
        end
        WAIT: begin
          settleCnt <= settleCnt + 1'b1;
        end
        ACCUM: begin
          chIdx <= chIdx + 1'b1;
          if (i_channelIsLeft[chIdx]) begin
            accL <= accL + chanExt;
          end else begin
            accR <= accR + chanExt;
          end
        end
        SCALE: begin
          pendL       <= satL[SAMPLE_WIDTH-1:0];
          pendR       <= satR[SAMPLE_WIDTH-1:0];
          o_mixStrobe <= 1'b1;
          o_clipped   <= satL[SAMPLE_WIDTH] | satR[SAMPLE_WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule
